uart_tx_frame_ctrl: RTL and testbench
=====================================

UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame (legal 5..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 data_valid  input  1  request to send p_data; single-cycle or level.
REQ-006 par_en  input  1  1 = insert parity bit after data bits.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 ser_data  output  1  current serialized data bit, LSB first; feeds the TX output mux.
REQ-009 par_bit  output  1  parity bit of the accepted word; feeds the TX output mux.
REQ-010 mux_select  output  2  00 start bit, 01 idle/stop, 10 ser_data, 11 par_bit.
REQ-011 busy  output  1  high while a frame is in progress.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; state held in a register.
REQ-013 mux_select decoded combinationally from state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-014 busy decoded from state: 0 in IDLE, 1 in START/DATA/PARITY/STOP.
REQ-015 Acceptance: in IDLE with data_valid=1 -> latch p_data into shift register, latch par_en, compute and register par_bit, next state START.
REQ-016 data_valid SHALL be ignored in START, DATA, PARITY; inputs p_data/par_en/par_typ changing mid-frame SHALL not affect the frame.
REQ-017 START lasts exactly 1 cycle -> DATA; bit counter cleared to 0.
REQ-018 DATA lasts exactly DATA_WIDTH cycles; ser_data = shift_reg[0]; shift register shifts right by 1 each DATA cycle; counter increments 0..DATA_WIDTH-1.
REQ-019 On last DATA cycle (counter = DATA_WIDTH-1): next state PARITY if latched par_en=1, else STOP.
REQ-020 PARITY lasts exactly 1 cycle -> STOP.
REQ-021 par_bit = XOR of all latched data bits when par_typ=0; inverted XOR when par_typ=1; stable from cycle after acceptance until next acceptance.
REQ-022 STOP lasts exactly 1 cycle; data_valid=1 in STOP -> accept new word (as REQ-015) and go to START (back-to-back, no idle cycle); otherwise -> IDLE.
REQ-023 Frame length in cycles: 1 + DATA_WIDTH + par_en + 1 (start through stop).
REQ-024 ser_data outside DATA state SHALL hold shift_reg[0] value; only meaningful while mux_select=10.
REQ-025 Counter SHALL never exceed DATA_WIDTH-1; no wrap-around within a frame.

Reset
REQ-026 rst=0 on rising edge: state IDLE, shift register 0, counter 0, par_bit 0, latched par_en 0.
REQ-027 Resulting outputs after reset: busy 0, mux_select 01, ser_data 0, par_bit 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately at that edge; no partial bits emitted afterward.
REQ-029 data_valid=1 coincident with rst=0 SHALL be ignored.

Verification
REQ-030 Reset: hold rst=0 two cycles with data_valid=1 -> busy 0, mux_select 01, par_bit 0 throughout.
REQ-031 No parity: p_data=8'hA5, par_en=0, one-cycle data_valid -> mux_select 00 x1, 10 x8 with ser_data 1,0,1,0,0,1,0,1, then 01; busy high exactly 10 cycles.
REQ-032 Even/odd parity: p_data=8'h07, par_en=1, par_typ=0 -> par_bit 1, PARITY cycle mux_select 11, busy 11 cycles; repeat with par_typ=1 -> par_bit 0.
REQ-033 Back-to-back: data_valid held high, p_data 8'h01 then 8'h80 -> STOP of first frame followed directly by START of second; no 01 cycle between frames except STOP.
REQ-034 Ignored request: data_valid pulse with p_data=8'hFF during DATA of 8'h00 frame -> frame bits all 0, no second frame started.
REQ-035 Mid-frame reset: rst=0 during 4th DATA cycle -> next cycle mux_select 01, busy 0; new data_valid afterward yields a complete correct frame.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, data (LSB first), optional
// parity and stop bits, and drives the select lines of the TX output mux.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic [1:0]            mux_select,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         cnt;
    logic                  par_en_q;
    logic                  accept;
    logic                  last_bit;

    assign last_bit = (cnt == LAST);
    assign ser_data = shift_reg[0];

    // State register; reset aborts any frame in progress at this edge.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic plus state-decoded mux select, busy and word acceptance.
    always_comb begin
        state_nxt  = state;
        mux_select = 2'b01;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                accept = data_valid;
                if (data_valid) state_nxt = START;
            end
            START: begin
                mux_select = 2'b00;
                state_nxt  = DATA;
            end
            DATA: begin
                mux_select = 2'b10;
                if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                mux_select = 2'b11;
                state_nxt  = STOP;
            end
            STOP: begin
                // A pending request here chains straight into the next start bit.
                accept    = data_valid;
                state_nxt = data_valid ? START : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch the word and its parity on acceptance, shift out during DATA.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg <= '0;
            cnt       <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= p_data;
                par_en_q  <= par_en;
                par_bit   <= (^p_data) ^ par_typ;
            end else if (state == DATA) begin
                shift_reg <= shift_reg >> 1;
            end
            if (state == START) begin
                cnt <= '0;
            end else if (state == DATA) begin
                // Park at zero after the last bit so the count never runs past the top.
                cnt <= last_bit ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: each scenario pushes the expected per-cycle
// frame into a scoreboard queue; a negedge monitor pops and compares while busy.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ser_data;
    logic       par_bit;
    logic [1:0] mux_select;
    logic       busy;

    typedef struct packed {
        logic [1:0] mux;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .mux_select (mux_select),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every busy cycle must match the next queued entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && busy === 1'b1) begin
            busy_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_busy_cycle mux_select=%b expected no frame", mux_select);
            end else begin
                e = sb.pop_front();
                if (mux_select !== e.mux) begin
                    errors++;
                    $display("FAIL frame_mux got %b expected %b", mux_select, e.mux);
                end else if (e.mux == 2'b10 && ser_data !== e.b) begin
                    errors++;
                    $display("FAIL frame_ser_data got %b expected %b", ser_data, e.b);
                end else if (e.mux == 2'b11 && par_bit !== e.b) begin
                    errors++;
                    $display("FAIL frame_par_bit got %b expected %b", par_bit, e.b);
                end
            end
        end else if (rst === 1'b1 && sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_gap busy=%b expected 1 with %0d entries pending", busy, sb.size());
        end
    end

    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_t e;
        e = '{mux: 2'b00, b: 1'b0};
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e = '{mux: 2'b10, b: d[i]};
            sb.push_back(e);
        end
        if (pe) begin
            e = '{mux: 2'b11, b: (^d) ^ pt};
            sb.push_back(e);
        end
        e = '{mux: 2'b01, b: 1'b0};
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; expectations queued once the accepting edge has passed.
    task automatic drive_word(input logic [7:0] d, input logic pe, input logic pt);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        push_frame(d, pe, pt);
    endtask

    task automatic wait_done(output bit timed_out);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 100) begin
            tick();
            n++;
        end
        timed_out = (n >= 100);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'hFF;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mux_select !== 2'b01 || par_bit !== 1'b0 || ser_data !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs busy=%b mux=%b par=%b ser=%b expected 0 01 0 0",
                         busy, mux_select, par_bit, ser_data);
            end
        end
        tick();
        data_valid = 1'b0;
        rst        = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || mux_select !== 2'b01) begin
            errors++;
            $display("FAIL reset_release busy=%b mux=%b expected 0 01", busy, mux_select);
        end
    endtask

    task automatic test_no_parity();
        bit to;
        busy_cnt = 0;
        drive_word(8'hA5, 1'b0, 1'b0);
        wait_done(to);
        checks++;
        if (to || busy_cnt != 10) begin
            errors++;
            $display("FAIL no_parity_len busy_cycles=%0d timeout=%0b expected 10", busy_cnt, to);
        end
    endtask

    task automatic test_parity(input logic pt, input logic exp_par);
        bit to;
        busy_cnt = 0;
        drive_word(8'h07, 1'b1, pt);
        // Mid-frame input changes must not disturb the frame or parity.
        p_data  = 8'h00;
        par_typ = ~pt;
        par_en  = 1'b0;
        wait_done(to);
        checks++;
        if (to || busy_cnt != 11) begin
            errors++;
            $display("FAIL parity_len typ=%b busy_cycles=%0d timeout=%0b expected 11", pt, busy_cnt, to);
        end
        checks++;
        if (par_bit !== exp_par) begin
            errors++;
            $display("FAIL parity_hold typ=%b got %b expected %b", pt, par_bit, exp_par);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        busy_cnt   = 0;
        p_data     = 8'h01;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        tick();
        push_frame(8'h01, 1'b0, 1'b0);
        push_frame(8'h80, 1'b0, 1'b0);
        p_data = 8'h80;
        repeat (10) tick();
        data_valid = 1'b0;
        wait_done(to);
        checks++;
        if (to || busy_cnt != 20) begin
            errors++;
            $display("FAIL back_to_back_len busy_cycles=%0d timeout=%0b expected 20", busy_cnt, to);
        end
    endtask

    task automatic test_ignored_request();
        bit to;
        busy_cnt = 0;
        drive_word(8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        p_data     = 8'hFF;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        wait_done(to);
        repeat (3) tick();
        checks++;
        if (to || busy_cnt != 10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_request busy_cycles=%0d busy=%b timeout=%0b expected 10 0",
                     busy_cnt, busy, to);
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        drive_word(8'hA5, 1'b1, 1'b0);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mux_select !== 2'b01 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b mux=%b ser=%b par=%b expected 0 01 0 0",
                     busy, mux_select, ser_data, par_bit);
        end
        tick();
        busy_cnt = 0;
        drive_word(8'h3C, 1'b1, 1'b1);
        wait_done(to);
        checks++;
        if (to || busy_cnt != 11) begin
            errors++;
            $display("FAIL post_reset_frame busy_cycles=%0d timeout=%0b expected 11", busy_cnt, to);
        end
    endtask

    initial begin
        rst        = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        test_reset();
        test_no_parity();
        test_parity(1'b0, 1'b1);
        test_parity(1'b1, 1'b0);
        test_back_to_back();
        test_ignored_request();
        test_mid_reset();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
